activation_ctrl_2: RTL and testbench

Sequencer for the second ReLU activation stage of the LeNet datapath. On `start` it streams all elements of a CHANNELS×ROWS×COLS feature-map buffer through a ReLU, one element per cycle. Source is a 1-cycle-latency read port; destination is a write port with `wr_ready` backpressure. It reports completion and the number of elements clipped to zero. It sits between the conv-2 output buffer and the pool-2 input buffer.

---
 rtl/activation_ctrl_2_if.sv | 24 ++
 rtl/activation_ctrl_2.sv | 186 ++++++++++++++++++
 tb/tb_activation_ctrl_2.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/activation_ctrl_2_if.sv
// Read port (1-cycle latency source) and write port (ready/valid sink)
// of the ReLU activation sequencer.
interface activation_ctrl_2_if #(
   parameter int unsigned BITWIDTH = 16,
   parameter int unsigned ADDR_W   = 8
);
   logic                rd_en;
   logic [ADDR_W-1:0]   rd_addr;
   logic [BITWIDTH-1:0] rd_data;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [BITWIDTH-1:0] wr_data;
   logic                wr_ready;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data,
      input  rd_data, wr_ready
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
      output rd_data, wr_ready
   );
endinterface

// File: rtl/activation_ctrl_2.sv
// Streams a CHANNELS x ROWS x COLS feature map through ReLU, one element per
// cycle, with a 2-entry output FIFO that absorbs sink backpressure.
module activation_ctrl_2 #(
   parameter int unsigned BITWIDTH = 16,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned ROWS     = 10,
   parameter int unsigned COLS     = 10,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_W-1:0]      neg_count,
   activation_ctrl_2_if.master   bus
);

   localparam int unsigned NUM_ELEMS = CHANNELS * ROWS * COLS;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ELEMS - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]   addr;
      logic [BITWIDTH-1:0] data;
   } entry_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              infl_q, infl_d;
   logic [ADDR_W-1:0] infl_addr_q, infl_addr_d;
   entry_t            head_q, head_d, tail_q, tail_d;
   logic              head_v_q, head_v_d, tail_v_q, tail_v_d;
   logic [CNT_W-1:0]  neg_d;
   logic              busy_d, done_d;

   logic              rd_en_c, pop_c, push_c, start_acc_c, room_c;
   logic [1:0]        occ_c;
   entry_t            push_e;

   // Register bank: FSM state, read index, in-flight tracking, FIFO, status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rd_addr_q   <= '0;
         infl_q      <= 1'b0;
         infl_addr_q <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         head_v_q    <= 1'b0;
         tail_v_q    <= 1'b0;
         neg_count   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         infl_q      <= infl_d;
         infl_addr_q <= infl_addr_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         head_v_q    <= head_v_d;
         tail_v_q    <= tail_v_d;
         neg_count   <= neg_d;
         busy        <= busy_d;
         done        <= done_d;
      end
   end

   // Next-state, issue rule, FIFO update and negative-element counting
   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      infl_d      = 1'b0;
      infl_addr_d = infl_addr_q;
      head_d      = head_q;
      tail_d      = tail_q;
      head_v_d    = head_v_q;
      tail_v_d    = tail_v_q;
      neg_d       = neg_count;

      occ_c       = {1'b0, head_v_q} + {1'b0, tail_v_q};
      pop_c       = head_v_q && bus.wr_ready;
      push_c      = infl_q && !abort;
      start_acc_c = (state_q == IDLE) && start && !abort;

      // A read may only be issued if its data is guaranteed a FIFO slot
      room_c  = ({1'b0, occ_c} + 3'(infl_q)) < (3'd2 + 3'(pop_c));
      rd_en_c = (state_q == RUN) && !abort && room_c;

      push_e.addr = infl_addr_q;
      push_e.data = bus.rd_data[BITWIDTH-1] ? '0 : bus.rd_data;

      if (rd_en_c) begin
         infl_d      = 1'b1;
         infl_addr_d = rd_addr_q;
      end

      if (abort) begin
         head_d   = '0;
         tail_d   = '0;
         head_v_d = 1'b0;
         tail_v_d = 1'b0;
      end else if (pop_c) begin
         if (tail_v_q) begin
            head_d = tail_q;
            if (push_c) begin
               tail_d = push_e;
            end else begin
               tail_d   = '0;
               tail_v_d = 1'b0;
            end
         end else if (push_c) begin
            head_d = push_e;
         end else begin
            head_d   = '0;
            head_v_d = 1'b0;
         end
      end else if (push_c) begin
         if (head_v_q) begin
            tail_d   = push_e;
            tail_v_d = 1'b1;
         end else begin
            head_d   = push_e;
            head_v_d = 1'b1;
         end
      end

      if (start_acc_c) begin
         neg_d = '0;
      end else if (push_c && bus.rd_data[BITWIDTH-1] && (neg_count != CNT_MAX)) begin
         neg_d = neg_count + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (start_acc_c) begin
               state_d   = RUN;
               rd_addr_d = '0;
            end
         end
         RUN: begin
            if (rd_en_c) begin
               if (rd_addr_q == LAST_ADDR) begin
                  state_d   = DRAIN;
                  rd_addr_d = '0;
               end else begin
                  rd_addr_d = rd_addr_q + ADDR_W'(1);
               end
            end
         end
         DRAIN: begin
            // Final element leaves when the FIFO empties with nothing in flight
            if (pop_c && !tail_v_q && !infl_q) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d   = IDLE;
         rd_addr_d = '0;
      end

      busy_d = (state_d == RUN) || (state_d == DRAIN);
      done_d = (state_d == DONE);
   end

   assign bus.rd_en   = rd_en_c;
   assign bus.rd_addr = rd_addr_q;
   assign bus.wr_en   = head_v_q;
   assign bus.wr_addr = head_q.addr;
   assign bus.wr_data = head_q.data;

endmodule

// File: tb/tb_activation_ctrl_2.sv
// Self-checking bench for activation_ctrl_2: spec-timing checks, corner data
// table, randomized data/backpressure against a ReLU reference model.
module tb_activation_ctrl_2;

   localparam int N = 200;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       busy;
   logic       done;
   logic [7:0] neg_count;

   activation_ctrl_2_if #(.BITWIDTH(16), .ADDR_W(8)) bus ();

   activation_ctrl_2 #(
      .BITWIDTH(16), .CHANNELS(2), .ROWS(10), .COLS(10), .ADDR_W(8), .CNT_W(8)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .neg_count (neg_count),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [0:255];

   // Source buffer: data valid the cycle after rd_en, junk otherwise
   always @(posedge clk) begin
      if (bus.rd_en === 1'b1) bus.rd_data <= mem[bus.rd_addr];
      else                    bus.rd_data <= 16'($urandom);
   end

   int vectors    = 0;
   int miscompares = 0;

   int q_addr[$];
   int q_data[$];
   int done_cyc, rd_first, rd_last, rd_cnt, wr_first, wr_last, last_pop, neg_at_done;

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int relu(input logic [15:0] x);
      return ($signed(x) < 0) ? 0 : int'(x);
   endfunction

   function automatic int model_neg(input int upto);
      int c = 0;
      for (int a = 0; a < upto; a++) if ($signed(mem[a]) < 0) c++;
      return (c > 255) ? 255 : c;
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"},    busy,        0);
      chk({tag, "_done"},    done,        0);
      chk({tag, "_rd_en"},   bus.rd_en,   0);
      chk({tag, "_wr_en"},   bus.wr_en,   0);
      chk({tag, "_rd_addr"}, bus.rd_addr, 0);
      chk({tag, "_wr_addr"}, bus.wr_addr, 0);
      chk({tag, "_wr_data"}, bus.wr_data, 0);
      chk({tag, "_neg"},     neg_count,   0);
   endtask

   // policy: 0 ready always, 1 random 50%, 2 stalled in cycles 5..24
   task automatic run_pass(input int policy, input int abort_cyc, input int rst_cyc);
      int     issued = 0, popped = 0;
      logic   prev_stall = 1'b0;
      logic [24:0] prev_out = '0;
      q_addr.delete(); q_data.delete();
      done_cyc = -1; rd_first = -1; rd_last = -1; rd_cnt = 0;
      wr_first = -1; wr_last = -1; last_pop = -1; neg_at_done = -1;

      @(posedge clk); #1;
      start = 1'b1; abort = 1'b0; bus.wr_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc < 3000; cyc++) begin
         case (policy)
            1:       bus.wr_ready = 1'($urandom_range(0, 1));
            2:       bus.wr_ready = !(cyc >= 5 && cyc <= 24);
            default: bus.wr_ready = 1'b1;
         endcase
         abort = (cyc == abort_cyc);
         if (cyc == rst_cyc) begin
            rst_n = 1'b0;
            #1;
            check_all_zero("async_rst");
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
         end
         #1;
         if (cyc == 1) begin
            chk("c1_busy", busy, 1);
            chk("c1_rd_en", bus.rd_en, 1);
            chk("c1_rd_addr", bus.rd_addr, 0);
            chk("c1_neg_clear", neg_count, 0);
         end
         if (bus.rd_en) begin
            chk("rd_addr_order", bus.rd_addr, issued);
            issued++; rd_cnt++;
            if (rd_first < 0) rd_first = cyc;
            rd_last = cyc;
         end
         if (bus.wr_en) begin
            if (wr_first < 0) wr_first = cyc;
            wr_last = cyc;
         end
         if (bus.wr_en && bus.wr_ready) begin
            q_addr.push_back(int'(bus.wr_addr));
            q_data.push_back(int'(bus.wr_data));
            popped++; last_pop = cyc;
         end
         if (!bus.wr_en) chk("wr_idle_zero", {bus.wr_addr, bus.wr_data}, 0);
         chk("fifo_le_2", (issued - popped) <= 2, 1);
         if (prev_stall) chk("stall_hold", {bus.wr_en, bus.wr_addr, bus.wr_data}, prev_out);
         prev_stall = bus.wr_en && !bus.wr_ready;
         prev_out   = {bus.wr_en, bus.wr_addr, bus.wr_data};
         if (policy == 2 && cyc >= 5 && cyc <= 24) begin
            chk("stall_rd_en", bus.rd_en, 0);
            chk("stall_busy", busy, 1);
         end
         if (done) begin
            done_cyc = cyc; neg_at_done = int'(neg_count);
            break;
         end
         chk("busy_run", busy, 1);
         if (cyc == abort_cyc) begin
            @(posedge clk); #1;
            abort = 1'b0;
            for (int k = 0; k < 20; k++) begin
               #1;
               chk("abort_busy", busy, 0);
               chk("abort_wr_en", bus.wr_en, 0);
               chk("abort_done", done, 0);
               chk("abort_neg_hold", neg_count, model_neg(abort_cyc - 2));
               @(posedge clk); #1;
            end
            return;
         end
         @(posedge clk); #1;
      end

      chk("done_seen", done_cyc > 0, 1);
      chk("write_count", q_addr.size(), N);
      for (int i = 0; i < q_addr.size() && i < N; i++) begin
         chk("wr_addr_seq", q_addr[i], i);
         chk("wr_data_relu", q_data[i], relu(mem[i]));
      end
      chk("neg_at_done", neg_at_done, model_neg(N));
      chk("done_after_last_write", done_cyc, last_pop + 1);
      if (policy == 0) begin
         chk("rd_first", rd_first, 1);
         chk("rd_last", rd_last, N);
         chk("rd_cnt", rd_cnt, N);
         chk("wr_first", wr_first, 3);
         chk("wr_last", wr_last, N + 2);
         chk("done_cycle", done_cyc, N + 3);
      end
      @(posedge clk); #2;
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
   endtask

   typedef struct {
      logic [15:0] din;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl [8];

   initial begin
      tbl[0] = '{16'h8000, 16'h0000};
      tbl[1] = '{16'hFFFF, 16'h0000};
      tbl[2] = '{16'h0000, 16'h0000};
      tbl[3] = '{16'h0001, 16'h0001};
      tbl[4] = '{16'h7FFF, 16'h7FFF};
      tbl[5] = '{16'h1234, 16'h1234};
      tbl[6] = '{16'hC000, 16'h0000};
      tbl[7] = '{16'h4000, 16'h4000};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; bus.wr_ready = 1'b1;
      for (int a = 0; a < 256; a++) mem[a] = 16'(a - 100);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 check_all_zero("reset");

      // Reset mid-RUN, then a full clean pass from address 0
      run_pass(0, 0, 50);
      run_pass(0, 0, 0);
      chk("ramp_neg", neg_at_done, 100);
      chk("ramp_done_203", done_cyc, 203);
      if (q_data.size() == N) begin
         chk("ramp_a50", q_data[50], 0);
         chk("ramp_a150", q_data[150], 50);
         chk("ramp_a199", q_data[199], 99);
      end

      // Corner data table
      for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
      for (int i = 0; i < 8; i++) mem[i] = tbl[i].din;
      run_pass(0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         if (i < q_data.size()) chk("corner_relu", q_data[i], int'(tbl[i].exp));
      end

      // Random data under random backpressure
      for (int r = 0; r < 3; r++) begin
         for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
         run_pass(1, 0, 0);
      end

      // Long stall from cycle 5
      for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
      run_pass(2, 0, 0);

      // Abort at cycle 60, then a full pass with neg_count cleared
      for (int a = 0; a < 256; a++) mem[a] = 16'(a - 100);
      run_pass(0, 60, 0);
      run_pass(0, 0, 0);
      chk("post_abort_neg", neg_at_done, 100);

      // abort together with start in IDLE: the pass must not begin
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      #1;
      chk("abort_wins_busy", busy, 0);
      chk("abort_wins_rd_en", bus.rd_en, 0);
      chk("abort_wins_neg", neg_count, 100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
